// File: rtl/rr_arb8_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arb8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic [7:0] seg;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  busy,
    input  seg
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output busy,
    output seg
  );
endinterface

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with hold limit and registered one-hot grant.
// Define RR_ARB8_SEG_EN to drive a seven-segment display of the owner index; otherwise seg = FF.
module rr_arb8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input logic       clk,
  input logic       rst,
  rr_arb8_if.slave  bus
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       idx_q, idx_d;

  logic       pick_valid;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       release_c;

  // First requester after the last owner, wrapping mod 8.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i < 9; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign release_c = bus.done || !bus.req[ptr_q] || (hold_q == HoldLast);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          ptr_d   = pick_idx;
          hold_d  = '0;
          gnt_d   = 8'h01 << pick_idx;
          idx_d   = pick_idx;
        end
      end
      StGrant: begin
        if (release_c) begin
          state_d = StIdle;
          gnt_d   = '0;
          idx_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 3'd7;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = (state_q == StGrant);

`ifdef RR_ARB8_SEG_EN
  logic [7:0] seg_q, seg_d;

  // Common-anode, active-low {dp,g..a}.
  function automatic logic [7:0] seg_decode(input logic [2:0] idx);
    logic [7:0] code;
    unique case (idx)
      3'd0:    code = 8'hC0;
      3'd1:    code = 8'hF9;
      3'd2:    code = 8'hA4;
      3'd3:    code = 8'hB0;
      3'd4:    code = 8'h99;
      3'd5:    code = 8'h92;
      3'd6:    code = 8'h82;
      default: code = 8'hF8;
    endcase
    return code;
  endfunction

  always_comb begin
    seg_d = 8'hFF;
    if (state_d == StGrant) begin
      seg_d = seg_decode(idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 8'hFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign bus.seg = seg_q;
`else
  assign bus.seg = 8'hFF;
`endif

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_rr_arb8;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  rr_arb8_if a ();
  rr_arb8_if b ();

  rr_arb8 #(.MAX_HOLD(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  rr_arb8 #(.MAX_HOLD(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_exp(input logic [2:0] idx);
    logic [7:0] code;
    case (idx)
      3'd0:    code = 8'hC0;
      3'd1:    code = 8'hF9;
      3'd2:    code = 8'hA4;
      3'd3:    code = 8'hB0;
      3'd4:    code = 8'h99;
      3'd5:    code = 8'h92;
      3'd6:    code = 8'h82;
      default: code = 8'hF8;
    endcase
    return code;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // owner < 0 means no owner expected.
  task automatic expect_owner(input string tag, input int owner);
    logic [7:0] eg;
    logic [7:0] es;
    logic [2:0] ei;
    logic       eb;
    if (owner < 0) begin
      eg = 8'h00;
      ei = 3'd0;
      eb = 1'b0;
      es = 8'hFF;
    end else begin
      eg = 8'h01 << owner;
      ei = 3'(owner);
      eb = 1'b1;
`ifdef RR_ARB8_SEG_EN
      es = seg_exp(ei);
`else
      es = 8'hFF;
`endif
    end
    chk({tag, ".gnt"}, a.gnt, eg);
    chk({tag, ".gnt_idx"}, {5'd0, a.gnt_idx}, {5'd0, ei});
    chk({tag, ".busy"}, {7'd0, a.busy}, {7'd0, eb});
    chk({tag, ".seg"}, a.seg, es);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    a.req  = 8'h00;
    a.done = 1'b0;
    b.req  = 8'h00;
    b.done = 1'b0;

    #1;
    expect_owner("reset", -1);
    chk("b_reset.gnt", b.gnt, 8'h00);
    tick();
    tick();

    // Single requester 0 after reset: ptr starts at 7, so 0 wins first.
    rst   = 1'b0;
    a.req = 8'h01;
    tick();
    expect_owner("req01_grant", 0);
    tick();
    expect_owner("req01_hold", 0);

    // Full rotation with done pulsed in each grant cycle.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    a.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_owner($sformatf("rr_grant%0d", k), k % 8);
      a.done = 1'b1;
      tick();
      a.done = 1'b0;
      expect_owner($sformatf("rr_idle%0d", k), -1);
    end

    // Hold limit: A (MAX_HOLD=4) holds 4 cycles; B (MAX_HOLD=1) toggles.
    a.req = 8'h08;
    b.req = 8'h08;
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_owner($sformatf("hold4_c%0d", k), (k == 4) ? -1 : 3);
      chk($sformatf("hold1_c%0d.gnt", k), b.gnt, (k % 2 == 0) ? 8'h08 : 8'h00);
    end
    b.req = 8'h00;

    // Owner 5 loses its request: next scan starts at 6, so 7 beats 2.
    a.req  = 8'h20;
    a.done = 1'b1;
    tick();
    a.done = 1'b0;
    expect_owner("to5_idle", -1);
    tick();
    expect_owner("own5", 5);
    a.req = 8'h84;
    tick();
    expect_owner("drop5_idle", -1);
    tick();
    expect_owner("next7", 7);

    // Asynchronous reset mid-grant, then scan restarts from 0.
    a.req = 8'h10;
    tick();
    expect_owner("drop7_idle", -1);
    tick();
    expect_owner("own4", 4);
    #2;
    rst = 1'b1;
    #1;
    expect_owner("async_rst", -1);
    tick();
    a.req = 8'h90;
    rst   = 1'b0;
    tick();
    expect_owner("post_rst", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, giving the maximum number of consecutive cycles one requester may hold the grant (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, 8, request lines; bit i means requester i asks for the shared resource.
REQ-005 SHALL have port done, input, 1, the current owner's release strobe; ignored in IDLE.
REQ-006 SHALL have port gnt, output, 8, one-hot registered grant; all-zero when no owner.
REQ-007 SHALL have port gnt_idx, output, 3, binary index of the current owner; 0 when no owner.
REQ-008 SHALL have port busy, output, 1, high while in GRANT.
REQ-009 SHALL have port seg, output, 8, common-anode active-low seven-segment code {dp,g..a} of gnt_idx.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and GRANT, plus a 3-bit last-owner pointer ptr and a hold counter sized for MAX_HOLD.
REQ-011 In IDLE with req != 0, SHALL pick the first set req bit scanning ptr+1, ptr+2, ... mod 8, and enter GRANT with gnt/gnt_idx/busy valid after that same edge (1-cycle latency).
REQ-012 In IDLE with req == 0, SHALL stay in IDLE with gnt=0, busy=0.
REQ-013 On entry to GRANT, SHALL clear the hold counter and set ptr to the new owner.
REQ-014 In GRANT, SHALL return to IDLE on the edge where done=1, or req[owner]=0, or the hold counter reaches MAX_HOLD-1; any one condition suffices, and simultaneous conditions are treated as one release.
REQ-015 In GRANT with no release condition, SHALL keep gnt unchanged and increment the hold counter; requests from other bits SHALL NOT pre-empt.
REQ-016 After release, SHALL spend exactly one cycle in IDLE (gnt=0) before the next grant, and arbitration then uses the updated ptr, so the released owner has lowest priority.
REQ-017 gnt SHALL never have more than one bit set, and SHALL never be set for a bit whose req was 0 at the granting edge.
REQ-018 seg SHALL be registered with gnt. Codes when busy: 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8 (hex). Code when not busy: FF (blank).
REQ-019 MAX_HOLD=1 SHALL force release after every single grant cycle.

Reset
REQ-020 While rst=1, SHALL asynchronously force state=IDLE, ptr=7, hold counter=0, gnt=0, gnt_idx=0, busy=0, seg=FF.
REQ-021 Reset asserted mid-grant SHALL drop gnt immediately without waiting for clk; after deassertion the first grant SHALL scan from index 0.

Configuration
REQ-022 Macro RR_ARB8_SEG_EN: when defined, seg SHALL behave per REQ-018; when undefined, the seg port SHALL remain and be tied to constant FF, with no segment-decode logic present.

Verification
REQ-023 Reset release, req=8'h01 held, done=0 -> gnt=01, gnt_idx=0, busy=1 after the first edge, and seg=C0 if RR_ARB8_SEG_EN is defined.
REQ-024 req=8'hFF held, each owner pulses done one cycle after its grant -> grant order 0,1,2,...,7,0 with one gnt=0 IDLE cycle between grants.
REQ-025 MAX_HOLD=4, req=8'h08 held, done=0 -> gnt=08 for exactly 4 cycles, 1 cycle at 0, then 08 again.
REQ-026 Owner 5 granted, req drops to 8'h84 (bit 5 cleared) -> release next edge, then grant 7 (scan from 6), not 2.
REQ-027 rst asserted asynchronously while gnt=10 -> gnt=0 and seg=FF before the next clk edge; after release with req=8'h90, first grant goes to 4.
REQ-028 Build without RR_ARB8_SEG_EN, run REQ-024 stimulus -> seg constant FF throughout, and gnt sequence identical to REQ-024.
